// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan controller for a common-anode seven-segment display with tear-free frame commit.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          load,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic ST_BLANK = 1'b0;
    localparam logic ST_SHOW  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic                    state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic                    frame_done_q, frame_done_d;

    logic [NUM_DIGITS-1:0]   supp;
    logic [3:0]              nibble;
    logic                    lit;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b0000001;
            4'h1: decode = 7'b1001111;
            4'h2: decode = 7'b0010010;
            4'h3: decode = 7'b0000110;
            4'h4: decode = 7'b1001100;
            4'h5: decode = 7'b0100100;
            4'h6: decode = 7'b0100000;
            4'h7: decode = 7'b0001111;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0001100;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b1100000;
            4'hC: decode = 7'b0110001;
            4'hD: decode = 7'b1000010;
            4'hE: decode = 7'b0110000;
            default: decode = 7'b0111000;
        endcase
    endfunction

    // The mask only reads the display register, which changes solely at the frame boundary.
`ifdef LEADING_ZERO_BLANK_EN
    logic seen_nz;
    always_comb begin
        seen_nz = 1'b0;
        supp    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen_nz = seen_nz | (disp_val_q[4*i +: 4] != 4'h0);
            supp[i] = ~seen_nz;
        end
    end
`else
    assign supp = '0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        digit_d = digit_q;
        if (cnt_q == CNT_LAST) begin
            digit_d = (digit_q == IDX_LAST) ? '0 : digit_q + IDX_W'(1);
        end

        state_d = state_q;
        case (state_q)
            ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
            default:  if (cnt_q == CNT_LAST)   state_d = ST_BLANK;
        endcase

        pend_val_d = load ? value : pend_val_q;
        pend_dp_d  = load ? dp_in : pend_dp_q;

        // Commit happens while digit 0 is still blanking, so a frame never mixes old and new data.
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        if (frame_done_q) begin
            disp_val_d = load ? value : pend_val_q;
            disp_dp_d  = load ? dp_in : pend_dp_q;
        end
    end

    always_comb begin
        nibble = disp_val_q[{digit_q, 2'b00} +: 4];
        lit    = (state_q == ST_SHOW) && !supp[digit_q];

        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = '1;
        if (lit) begin
            seg_d         = decode(nibble);
            dp_d          = ~disp_dp_q[digit_q];
            an_d[digit_q] = 1'b0;
        end
        digit_idx_d  = digit_q;
        frame_done_d = (cnt_q == CNT_LAST) && (digit_q == IDX_LAST);
    end

    // NOTE: state is updated with non-blocking assignments only; blocking here would race other flops.
    // NOTE: pending/display registers are reset too, because a blank-slate display of zeros is visible behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            digit_q      <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
            digit_idx_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            digit_idx_q  <= digit_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign digit_idx  = digit_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner (4 digits, 8-clock slots, 2 blank clocks).
// Expectations follow LEADING_ZERO_BLANK_EN when the bench is built with it.
module tb_seven_seg_scanner;

    localparam int NUM_DIGITS   = 4;
    localparam int REFRESH_DIV  = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = NUM_DIGITS * REFRESH_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Hand-written glyph table, bit order a..g, 0 = lit.
    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seven_seg_scanner #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .dp_in     (dp_in),
        .load      (load),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .digit_idx (digit_idx),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " seg"}, 32'(seg), 32'h7F);
        check({tag, " an"}, 32'(an), 32'hF);
        check({tag, " dp"}, 32'(dp), 32'h1);
        check({tag, " idx"}, 32'(digit_idx), 32'h0);
        check({tag, " fd"}, 32'(frame_done), 32'h0);
    endtask

    // Checks one frame (or its first last_k+1 cycles) of outputs against the expected
    // display contents; optionally pulses load with new data right after cycle inj_k.
    task automatic run_frame(input string tag, input logic [15:0] ev, input logic [3:0] edp,
                             input int last_k, input int inj_k,
                             input logic [15:0] iv, input logic [3:0] idp);
        int         d, ph;
        logic       supp;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        logic [3:0] nib;
        string      t;
        for (int k = 0; k <= last_k; k++) begin
            tick();
            load = 1'b0;
            d    = k / REFRESH_DIV;
            ph   = k % REFRESH_DIV;
            nib  = 4'((ev >> (4 * d)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
            supp = (d != 0) && ((ev >> (4 * d)) == 16'h0);
`else
            supp = 1'b0;
`endif
            if (ph < BLANK_CYCLES || supp) begin
                exp_an  = 4'hF;
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
            end else begin
                exp_an  = ~(4'b0001 << d);
                exp_seg = glyph[nib];
                exp_dp  = ~edp[d];
            end
            t = $sformatf("%s k%0d", tag, k);
            check({t, " an"}, 32'(an), 32'(exp_an));
            check({t, " seg"}, 32'(seg), 32'(exp_seg));
            check({t, " dp"}, 32'(dp), 32'(exp_dp));
            check({t, " idx"}, 32'(digit_idx), 32'(d));
            check({t, " fd"}, 32'(frame_done), 32'(k == FRAME - 1));
            if (k == inj_k) begin
                load  = 1'b1;
                value = iv;
                dp_in = idp;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        value = 16'h0;
        dp_in = 4'h0;
        load  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset_outputs($sformatf("rst%0d", i));
        end

        // Load during the first frame; that frame still shows the cleared display.
        rst   = 1'b0;
        load  = 1'b1;
        value = 16'h1208;
        dp_in = 4'b0010;
        run_frame("f1_zero", 16'h0000, 4'b0000, FRAME - 1, -1, 16'h0, 4'h0);

        // Mid-frame load must not tear the current frame.
        run_frame("f2_1208", 16'h1208, 4'b0010, FRAME - 1, 11, 16'hABCD, 4'b0000);
        // Load coinciding with frame_done goes straight to the next frame.
        run_frame("f3_abcd", 16'hABCD, 4'b0000, FRAME - 1, FRAME - 1, 16'h5E07, 4'b1001);
        run_frame("f4_5e07", 16'h5E07, 4'b1001, FRAME - 1, -1, 16'h0, 4'h0);

        // Reset in the middle of digit 2's SHOW.
        run_frame("f5_part", 16'h5E07, 4'b1001, 19, -1, 16'h0, 4'h0);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        run_frame("f6_zero", 16'h0000, 4'b0000, FRAME - 1, -1, 16'h0, 4'h0);
        run_frame("f7_zero", 16'h0000, 4'b0000, FRAME - 1, FRAME - 1, 16'h0042, 4'b1100);

        run_frame("f8_0042", 16'h0042, 4'b1100, FRAME - 1, FRAME - 1, 16'h0000, 4'b1111);
        run_frame("f9_0000", 16'h0000, 4'b1111, FRAME - 1, -1, 16'h0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
